// File: rtl/ball_kinematics.sv
// rtl/ball_kinematics.sv - Pong ball motion engine: position, direction, speed, serve and miss handling
// Optional paddle-hit speed-up is enabled by defining BALL_SPEEDUP_EN.
module ball_kinematics #(
   parameter int X_W           = 10,
   parameter int Y_W           = 9,
   parameter int SCREEN_W      = 640,
   parameter int SCREEN_H      = 480,
   parameter int BALL_SIZE     = 8,
   parameter int TICK_DIV      = 833333,
   parameter int SPEED_INIT    = 1,
   parameter int SPEED_MAX     = 7,
   parameter int HITS_PER_STEP = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           serve,
   input  logic           serve_dir,
   input  logic           paddle_collision,
   input  logic           wall_collision,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o,
   output logic           bx_dir,
   output logic           by_dir,
   output logic [2:0]     speed_o,
   output logic           in_play,
   output logic           miss_left,
   output logic           miss_right
);

   localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int HIT_W  = $clog2(HITS_PER_STEP + 1);

   localparam logic [X_W-1:0] X_CTR = X_W'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [Y_W-1:0] Y_CTR = Y_W'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W - BALL_SIZE);
   localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H - BALL_SIZE);

   localparam logic signed [X_W:0] X_LIM_S = (X_W+1)'(SCREEN_W - BALL_SIZE);
   localparam logic signed [Y_W:0] Y_LIM_S = (Y_W+1)'(SCREEN_H - BALL_SIZE);
   localparam logic signed [Y_W:0] Y_STEP  = (Y_W+1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      MISS
   } state_t;

   state_t            state;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic              pf;
   logic              wf;
   logic [HIT_W-1:0]  hit_cnt;

   logic              pf_now;
   logic              wf_now;
   logic              bx_next;
   logic              by_next;
   logic [HIT_W-1:0]  hit_inc;
   logic              hit_full;
   logic              step_up;
   logic [2:0]        speed_up;
   logic signed [X_W:0] x_ext;
   logic signed [X_W:0] sp_ext;
   logic signed [X_W:0] nx;
   logic signed [Y_W:0] y_ext;
   logic signed [Y_W:0] ny;

   assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TICK_W'(1);
      end
   end

   // A collision strobe landing on the tick cycle itself is folded into that tick.
   assign pf_now  = pf | paddle_collision;
   assign wf_now  = wf | wall_collision;
   assign bx_next = bx_dir ^ pf_now;
   assign by_next = by_dir ^ wf_now;

   assign hit_inc  = hit_cnt + HIT_W'(pf_now);
   assign hit_full = (hit_inc == HIT_W'(HITS_PER_STEP));
   assign speed_up = (speed_o >= 3'(SPEED_MAX)) ? speed_o : speed_o + 3'd1;

`ifdef BALL_SPEEDUP_EN
   assign step_up = hit_full;
`else
   assign step_up = 1'b0;
`endif

   // One extra signed bit lets a step past either edge show up as a sign or overflow.
   assign x_ext  = signed'({1'b0, x_o});
   assign sp_ext = signed'((X_W+1)'(speed_o));
   assign nx     = bx_next ? (x_ext + sp_ext) : (x_ext - sp_ext);
   assign y_ext  = signed'({1'b0, y_o});
   assign ny     = by_next ? (y_ext + Y_STEP) : (y_ext - Y_STEP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pf         <= 1'b0;
         wf         <= 1'b0;
         hit_cnt    <= '0;
         x_o        <= X_CTR;
         y_o        <= Y_CTR;
         bx_dir     <= 1'b0;
         by_dir     <= 1'b0;
         speed_o    <= 3'(SPEED_INIT);
         in_play    <= 1'b0;
         miss_left  <= 1'b0;
         miss_right <= 1'b0;
      end else begin
         miss_left  <= 1'b0;
         miss_right <= 1'b0;
         case (state)
            IDLE: begin
               pf <= 1'b0;
               wf <= 1'b0;
               if (serve) begin
                  state   <= PLAY;
                  in_play <= 1'b1;
                  bx_dir  <= serve_dir;
                  by_dir  <= 1'b1;
                  speed_o <= 3'(SPEED_INIT);
                  hit_cnt <= '0;
               end
            end
            PLAY: begin
               if (tick) begin
                  pf      <= 1'b0;
                  wf      <= 1'b0;
                  bx_dir  <= bx_next;
                  hit_cnt <= hit_full ? '0 : hit_inc;
                  if (step_up) begin
                     speed_o <= speed_up;
                  end
                  if (nx[X_W]) begin
                     x_o       <= '0;
                     miss_left <= 1'b1;
                     in_play   <= 1'b0;
                     state     <= MISS;
                  end else if (nx > X_LIM_S) begin
                     x_o        <= X_LIM;
                     miss_right <= 1'b1;
                     in_play    <= 1'b0;
                     state      <= MISS;
                  end else begin
                     x_o <= nx[X_W-1:0];
                  end
                  // Edge bounces take precedence over a pending wall toggle.
                  if (ny[Y_W]) begin
                     y_o    <= '0;
                     by_dir <= 1'b1;
                  end else if (ny > Y_LIM_S) begin
                     y_o    <= Y_LIM;
                     by_dir <= 1'b0;
                  end else begin
                     y_o    <= ny[Y_W-1:0];
                     by_dir <= by_next;
                  end
               end else begin
                  pf <= pf_now;
                  wf <= wf_now;
               end
            end
            MISS: begin
               pf <= 1'b0;
               wf <= 1'b0;
               if (tick) begin
                  state  <= IDLE;
                  x_o    <= X_CTR;
                  y_o    <= Y_CTR;
                  by_dir <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ball_kinematics.sv
// tb/tb_ball_kinematics.sv - scoreboard bench for ball_kinematics against a cycle-level reference model
module tb_ball_kinematics;

   localparam int TICK   = 4;
   localparam int SW     = 640;
   localparam int SH     = 480;
   localparam int BS     = 8;
   localparam int SP_INI = 1;
   localparam int SP_MAX = 7;
   localparam int HPS    = 4;
   localparam int XC     = (SW - BS) / 2;
   localparam int YC     = (SH - BS) / 2;
   localparam int XL     = SW - BS;
   localparam int YL     = SH - BS;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       serve = 1'b0;
   logic       serve_dir = 1'b0;
   logic       paddle_collision = 1'b0;
   logic       wall_collision = 1'b0;
   logic [9:0] x_o;
   logic [8:0] y_o;
   logic       bx_dir;
   logic       by_dir;
   logic [2:0] speed_o;
   logic       in_play;
   logic       miss_left;
   logic       miss_right;

   ball_kinematics #(
      .X_W(10), .Y_W(9), .SCREEN_W(SW), .SCREEN_H(SH), .BALL_SIZE(BS),
      .TICK_DIV(TICK), .SPEED_INIT(SP_INI), .SPEED_MAX(SP_MAX), .HITS_PER_STEP(HPS)
   ) dut (
      .clk(clk), .reset(reset), .serve(serve), .serve_dir(serve_dir),
      .paddle_collision(paddle_collision), .wall_collision(wall_collision),
      .x_o(x_o), .y_o(y_o), .bx_dir(bx_dir), .by_dir(by_dir), .speed_o(speed_o),
      .in_play(in_play), .miss_left(miss_left), .miss_right(miss_right)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      bit bx;
      bit by;
      int speed;
      bit in_play;
      bit ml;
      bit mr;
   } snap_t;

   snap_t exp_q[$];
   int    checks = 0;
   int    fails  = 0;

   // Reference state: mode 0 = waiting for serve, 1 = ball moving, 2 = ball out
   int m_x, m_y, m_speed, m_hits, m_mode, m_phase;
   bit m_bx, m_by, m_inplay, m_ml, m_mr, m_pf, m_wf;

   function automatic void model_step();
      snap_t s;
      bit    on_tick;
      bit    p;
      bit    w;
      int    nx;
      int    ny;
      if (reset) begin
         m_x = XC; m_y = YC; m_bx = 0; m_by = 0; m_speed = SP_INI;
         m_inplay = 0; m_ml = 0; m_mr = 0; m_pf = 0; m_wf = 0;
         m_hits = 0; m_mode = 0; m_phase = 0;
      end else begin
         on_tick = (m_phase == TICK - 1);
         m_phase = (m_phase + 1) % TICK;
         m_ml = 0;
         m_mr = 0;
         if (m_mode == 0) begin
            if (serve) begin
               m_mode = 1; m_inplay = 1; m_bx = serve_dir; m_by = 1;
               m_speed = SP_INI; m_hits = 0;
            end
         end else if (m_mode == 1) begin
            p = m_pf || paddle_collision;
            w = m_wf || wall_collision;
            if (on_tick) begin
               if (p) begin
                  m_bx = !m_bx;
                  m_hits++;
               end
               if (w) m_by = !m_by;
               nx = m_x + (m_bx ? m_speed : -m_speed);
               ny = m_y + (m_by ? 1 : -1);
               if (m_hits == HPS) begin
`ifdef BALL_SPEEDUP_EN
                  m_speed = (m_speed + 1 > SP_MAX) ? SP_MAX : m_speed + 1;
`endif
                  m_hits = 0;
               end
               if (nx < 0) begin
                  m_x = 0; m_ml = 1; m_mode = 2; m_inplay = 0;
               end else if (nx > XL) begin
                  m_x = XL; m_mr = 1; m_mode = 2; m_inplay = 0;
               end else begin
                  m_x = nx;
               end
               if (ny < 0) begin
                  m_y = 0; m_by = 1;
               end else if (ny > YL) begin
                  m_y = YL; m_by = 0;
               end else begin
                  m_y = ny;
               end
               m_pf = 0;
               m_wf = 0;
            end else begin
               m_pf = p;
               m_wf = w;
            end
         end else begin
            if (on_tick) begin
               m_mode = 0; m_x = XC; m_y = YC; m_by = 0;
            end
         end
      end
      s.x = m_x; s.y = m_y; s.bx = m_bx; s.by = m_by; s.speed = m_speed;
      s.in_play = m_inplay; s.ml = m_ml; s.mr = m_mr;
      exp_q.push_back(s);
   endfunction

   always @(negedge clk) begin
      snap_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (int'(x_o) != e.x || int'(y_o) != e.y || bx_dir != e.bx || by_dir != e.by ||
             int'(speed_o) != e.speed || in_play != e.in_play ||
             miss_left != e.ml || miss_right != e.mr) begin
            fails++;
            $display("FAIL cycle_state t=%0t got x=%0d y=%0d bx=%0b by=%0b spd=%0d play=%0b ml=%0b mr=%0b exp x=%0d y=%0d bx=%0b by=%0b spd=%0d play=%0b ml=%0b mr=%0b",
                     $time, x_o, y_o, bx_dir, by_dir, speed_o, in_play, miss_left, miss_right,
                     e.x, e.y, e.bx, e.by, e.speed, e.in_play, e.ml, e.mr);
         end
      end
   end

   task automatic drive(input bit r, input bit s, input bit sd, input bit p, input bit w);
      reset = r;
      serve = s;
      serve_dir = sd;
      paddle_collision = p;
      wall_collision = w;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1);
      idle(3);
      // Serve right, then wall and paddle+wall pulses mid-interval
      drive(0, 1, 1, 0, 0);
      idle(10);
      drive(0, 0, 0, 0, 1);
      idle(5);
      drive(0, 0, 0, 1, 1);
      idle(5);
      // One paddle pulse in each of four successive tick intervals
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 1, 0);
         idle(3);
      end
      idle(12);
      // Reset with a wall flag pending, reset beating a concurrent serve
      drive(0, 0, 0, 0, 1);
      drive(1, 1, 0, 0, 0);
      idle(2);
      drive(0, 1, 0, 0, 0);
      idle(12);
      // Run out to the left edge, then to the right edge
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      idle(1300);
      drive(0, 1, 1, 0, 0);
      idle(1300);
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0, 1'($urandom),
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      end
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain got %0d left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
